dft_peak_search: RTL and testbench
==================================

Name: dft_peak_search

Overview:
Downstream stage of the DFT accumulator. It consumes the NUM_BINS complex accumulator values when the accumulator pulses its done strobe, and snapshots them. It then scans the bins serially through a pipelined power unit, computing |A[k]|^2 for each bin. It reports the peak bin index and its power to the host/APU over a valid/ready handshake.

Parameters:
NUM_BINS, 16, number of bins; power of two, at least 2
ACCUM_WIDTH, 48, width of input accumulator real/imag parts
SQ_IN_WIDTH, 24, retained MSBs of each part before squaring; must be less than or equal to ACCUM_WIDTH
POWER_WIDTH (localparam), 2*SQ_IN_WIDTH+1, width of power values
BIN_IDX_WIDTH (localparam), $clog2(NUM_BINS), width of bin index

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
valid_i  in  1  one-cycle strobe from the accumulator: A arrays are valid
A_real_i  in  ACCUM_WIDTH x NUM_BINS  signed accumulator real parts
A_imag_i  in  ACCUM_WIDTH x NUM_BINS  signed accumulator imaginary parts
result_valid_o  out  1  peak result available
result_ready_i  in  1  consumer accepts result
peak_bin_o  out  BIN_IDX_WIDTH  index of max-power bin
peak_power_o  out  POWER_WIDTH  power of that bin (unsigned)
busy_o  out  1  high in SCAN, DRAIN, RESULT
overrun_o  out  1  one-cycle pulse when valid_i is dropped

Behaviour:
- Interface: reset rst_ni, asynchronous, active-low; clock clk_i. All state uses async reset.
- Reset values: result_valid_o=0, peak_bin_o=0, peak_power_o=0, busy_o=0, overrun_o=0. Snapshot registers, the running max and the pipeline are cleared. FSM goes to IDLE.
- Reset mid-operation: the current scan is abandoned and nothing is output.
- FSM states: IDLE, SCAN, DRAIN, RESULT.
  - IDLE: when valid_i=1, register all A_real_i/A_imag_i into the snapshot, clear the bin counter and the running max (max=0, idx=0), and go to SCAN.
  - SCAN: issue snapshot bin k=counter into the power pipe each cycle and increment the counter. After issuing bin NUM_BINS-1, go to DRAIN. The counter does not wrap during a scan.
  - DRAIN: wait 2 cycles for the pipe to empty, then go to RESULT.
  - RESULT: result_valid_o=1. peak_bin_o and peak_power_o are held stable until result_valid_o and result_ready_i are both high. The handshake completes in that cycle and the next state is IDLE.
- Power pipe, 2 stages:
  - Stage 1: truncate each part to its top SQ_IN_WIDTH bits (arithmetic shift right by ACCUM_WIDTH-SQ_IN_WIDTH), then square each part.
  - Stage 2: power = re^2 + im^2, unsigned, POWER_WIDTH bits, no overflow possible. Compare against the running max in the same cycle.
  - Bin index travels alongside the data through the pipe.
- Compare rule: update only when power > max (strictly greater). Ties keep the lowest index. If all bins are zero, the result is bin 0 with power 0.
- Latency: with the valid_i-sampling edge as edge 0, result_valid_o is high after edge NUM_BINS+3. Scan throughput is one bin per cycle.
- valid_i is ignored in every state except IDLE, and overrun_o pulses 1 cycle. This includes valid_i in the same cycle as the RESULT handshake.
- result_ready_i held high while entering RESULT: result_valid_o is high for exactly 1 cycle.

Optional Feature:
Macro PEAK_NEIGHBOURS_EN.
- Defined: adds outputs peak_left_power_o and peak_right_power_o, each POWER_WIDTH bits. They carry the powers of bins peak-1 and peak+1, for interpolation downstream. They are 0 at the edges (peak=0 gives left 0; peak=NUM_BINS-1 gives right 0).
  - Implementation: keep a delayed copy of the previous power. Latch left power and arm a capture of right power when the peak updates.
  - Neighbour outputs are valid with result_valid_o and reset to 0.
- Undefined: these ports and their logic are absent. Everything else is identical.

Decomposition:
- Package dft_pkg:
  - peak_state_t enum (IDLE/SCAN/DRAIN/RESULT)
  - default parameter constants shared with the accumulator (ACCUM_WIDTH, NUM_BINS)
  - function for the POWER_WIDTH derivation
- Sub-module dft_bin_power: 2-stage truncate/square/sum pipe. Ports: clk_i, rst_ni, in_valid, re, im, bin index in; out_valid, power, bin index out.

Test Plan:
All tests use NUM_BINS=16, ACCUM_WIDTH=48, SQ_IN_WIDTH=24, so the truncation shift is 24.
1. Single peak: A_real[5]=3<<24, A_imag[5]=4<<24, others 0, valid_i pulse -> result_valid_o after edge 19, peak_bin_o=5, peak_power_o=25.
2. Tie and negatives: A_real[2]=-2<<24, A_imag[9]=2<<24 -> peak_bin_o=2, peak_power_o=4.
3. All-zero input -> peak_bin_o=0, peak_power_o=0. Also A_real[15]=1<<23 only (truncates to 0) -> peak_bin_o=0.
4. Backpressure: hold result_ready_i=0 for 10 cycles -> outputs stable and valid high. Then ready=1 -> valid drops the next cycle and busy_o=0. A valid_i pulse during the hold -> overrun_o pulses once and the result is unchanged.
5. Reset mid-scan: deassert rst_ni at edge 8 -> all outputs 0 and IDLE. A new valid_i after reset -> correct result for the new data.
6. PEAK_NEIGHBOURS_EN: powers 4 and 9 placed around peak bin 0 with power 25 -> left=0, right=bin 1 power. For peak bin 7: left=bin 6 power, right=bin 8 power.

Source files
------------

// File: rtl/dft_pkg.sv
// ============================================================================
//  Module   : dft_pkg
//  Purpose  : Shared types and constants for the DFT accumulator / peak search
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dft_pkg;

   localparam int DFT_NUM_BINS    = 16;
   localparam int DFT_ACCUM_WIDTH = 48;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      DRAIN  = 2'd2,
      RESULT = 2'd3
   } peak_state_t;

   // re^2 + im^2 of two sq_in_width-bit signed values always fits here.
   function automatic int dft_power_width(input int sq_in_width);
      return 2 * sq_in_width + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dft_bin_power.sv
// ============================================================================
//  Module   : dft_bin_power
//  Purpose  : Two-stage truncate / square / sum power pipe, bin index alongside
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_bin_power
   import dft_pkg::*;
#(
   parameter int ACCUM_WIDTH  = DFT_ACCUM_WIDTH,
   parameter int SQ_IN_WIDTH  = 24,
   parameter int IDX_WIDTH    = 4,
   localparam int POWER_WIDTH = dft_power_width(SQ_IN_WIDTH)
)(
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   i_valid,
   input  logic [ACCUM_WIDTH-1:0] i_re,
   input  logic [ACCUM_WIDTH-1:0] i_im,
   input  logic [IDX_WIDTH-1:0]   i_bin,
   output logic                   o_valid,
   output logic [POWER_WIDTH-1:0] o_power,
   output logic [IDX_WIDTH-1:0]   o_bin
);

   localparam int SHIFT = ACCUM_WIDTH - SQ_IN_WIDTH;

   logic signed [2*SQ_IN_WIDTH-1:0] w_re_ext, w_im_ext;
   logic signed [2*SQ_IN_WIDTH-1:0] w_re_sq, w_im_sq;
   logic [2*SQ_IN_WIDTH-1:0]        r_re_sq, r_im_sq;
   logic                            r_valid1;
   logic [IDX_WIDTH-1:0]            r_bin1;

   // The top SQ_IN_WIDTH bits equal an arithmetic shift by SHIFT, sign-extended
   // so the product is formed at full width.
   assign w_re_ext = {{SQ_IN_WIDTH{i_re[ACCUM_WIDTH-1]}}, i_re[ACCUM_WIDTH-1 -: SQ_IN_WIDTH]};
   assign w_im_ext = {{SQ_IN_WIDTH{i_im[ACCUM_WIDTH-1]}}, i_im[ACCUM_WIDTH-1 -: SQ_IN_WIDTH]};
   assign w_re_sq  = w_re_ext * w_re_ext;
   assign w_im_sq  = w_im_ext * w_im_ext;

   generate
      if (SHIFT > 0) begin : g_discard_lsbs
         logic w_unused_lsbs;
         assign w_unused_lsbs = ^{i_re[SHIFT-1:0], i_im[SHIFT-1:0]};
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid1 <= 1'b0;
         r_bin1   <= '0;
         r_re_sq  <= '0;
         r_im_sq  <= '0;
         o_valid  <= 1'b0;
         o_bin    <= '0;
         o_power  <= '0;
      end else begin
         r_valid1 <= i_valid;
         r_bin1   <= i_bin;
         r_re_sq  <= w_re_sq;
         r_im_sq  <= w_im_sq;
         o_valid  <= r_valid1;
         o_bin    <= r_bin1;
         o_power  <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
      end
   end

endmodule

`default_nettype wire

// File: rtl/dft_peak_search.sv
// ============================================================================
//  Module   : dft_peak_search
//  Purpose  : Snapshots DFT bins, scans their power serially, reports the peak.
//             Optional macro PEAK_NEIGHBOURS_EN adds neighbour-bin power outputs.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dft_peak_search
   import dft_pkg::*;
#(
   parameter int NUM_BINS       = DFT_NUM_BINS,
   parameter int ACCUM_WIDTH    = DFT_ACCUM_WIDTH,
   parameter int SQ_IN_WIDTH    = 24,
   localparam int POWER_WIDTH   = dft_power_width(SQ_IN_WIDTH),
   localparam int BIN_IDX_WIDTH = $clog2(NUM_BINS)
)(
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic                            valid_i,
   input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_real_i,
   input  logic [NUM_BINS*ACCUM_WIDTH-1:0] A_imag_i,
   output logic                            result_valid_o,
   input  logic                            result_ready_i,
   output logic [BIN_IDX_WIDTH-1:0]        peak_bin_o,
   output logic [POWER_WIDTH-1:0]          peak_power_o,
   output logic                            busy_o,
   output logic                            overrun_o
`ifdef PEAK_NEIGHBOURS_EN
   ,
   output logic [POWER_WIDTH-1:0]          peak_left_power_o,
   output logic [POWER_WIDTH-1:0]          peak_right_power_o
`endif
);

   localparam logic [BIN_IDX_WIDTH-1:0] LAST_BIN = BIN_IDX_WIDTH'(NUM_BINS - 1);

   peak_state_t              r_state, w_state_nxt;
   logic [ACCUM_WIDTH-1:0]   r_snap_re [NUM_BINS];
   logic [ACCUM_WIDTH-1:0]   r_snap_im [NUM_BINS];
   logic [BIN_IDX_WIDTH-1:0] r_cnt;
   logic [1:0]               r_drain;
   logic [BIN_IDX_WIDTH-1:0] r_max_idx;
   logic [POWER_WIDTH-1:0]   r_max_power;
   logic                     r_overrun;
   logic                     w_pipe_valid;
   logic [POWER_WIDTH-1:0]   w_pipe_power;
   logic [BIN_IDX_WIDTH-1:0] w_pipe_bin;
   logic                     w_start;
   logic                     w_update;

   assign w_start  = (r_state == IDLE) && valid_i;
   assign w_update = w_pipe_valid && (w_pipe_power > r_max_power);

   dft_bin_power #(
      .ACCUM_WIDTH (ACCUM_WIDTH),
      .SQ_IN_WIDTH (SQ_IN_WIDTH),
      .IDX_WIDTH   (BIN_IDX_WIDTH)
   ) u_bin_power (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .i_valid (r_state == SCAN),
      .i_re    (r_snap_re[r_cnt]),
      .i_im    (r_snap_im[r_cnt]),
      .i_bin   (r_cnt),
      .o_valid (w_pipe_valid),
      .o_power (w_pipe_power),
      .o_bin   (w_pipe_bin)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   // DRAIN holds until the last bin has left both pipe stages and been compared.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (valid_i)            w_state_nxt = SCAN;
         SCAN:    if (r_cnt == LAST_BIN)  w_state_nxt = DRAIN;
         DRAIN:   if (r_drain == 2'd2)    w_state_nxt = RESULT;
         RESULT:  if (result_ready_i)     w_state_nxt = IDLE;
         default:                         w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < NUM_BINS; k++) begin
            r_snap_re[k] <= '0;
            r_snap_im[k] <= '0;
         end
         r_cnt       <= '0;
         r_drain     <= '0;
         r_max_idx   <= '0;
         r_max_power <= '0;
         r_overrun   <= 1'b0;
      end else begin
         r_overrun <= valid_i && (r_state != IDLE);
         r_drain   <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
         if ((r_state == SCAN) && (r_cnt != LAST_BIN)) r_cnt <= r_cnt + 1'b1;
         if (w_update) begin
            r_max_power <= w_pipe_power;
            r_max_idx   <= w_pipe_bin;
         end
         if (w_start) begin
            for (int k = 0; k < NUM_BINS; k++) begin
               r_snap_re[k] <= A_real_i[k*ACCUM_WIDTH +: ACCUM_WIDTH];
               r_snap_im[k] <= A_imag_i[k*ACCUM_WIDTH +: ACCUM_WIDTH];
            end
            r_cnt       <= '0;
            r_max_idx   <= '0;
            r_max_power <= '0;
         end
      end
   end

`ifdef PEAK_NEIGHBOURS_EN
   logic [POWER_WIDTH-1:0] r_prev_power, r_left, r_right;
   logic                   r_arm;

   // Bins leave the pipe in order, so the previous power is always bin k-1.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prev_power <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_arm        <= 1'b0;
      end else if (w_start) begin
         r_prev_power <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_arm        <= 1'b0;
      end else if (w_pipe_valid) begin
         r_prev_power <= w_pipe_power;
         if (w_update) begin
            r_left  <= r_prev_power;
            r_right <= '0;
            r_arm   <= 1'b1;
         end else if (r_arm) begin
            r_right <= w_pipe_power;
            r_arm   <= 1'b0;
         end
      end
   end

   assign peak_left_power_o  = r_left;
   assign peak_right_power_o = r_right;
`endif

   assign result_valid_o = (r_state == RESULT);
   assign busy_o         = (r_state != IDLE);
   assign overrun_o      = r_overrun;
   assign peak_bin_o     = r_max_idx;
   assign peak_power_o   = r_max_power;

endmodule

`default_nettype wire

// File: tb/tb_dft_peak_search.sv
// ============================================================================
//  Module   : tb_dft_peak_search
//  Purpose  : Directed self-checking bench for dft_peak_search (16 bins, 48/24)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dft_peak_search;

   localparam int NB = 16;
   localparam int AW = 48;
   localparam int SQ = 24;
   localparam int PW = 49;
   localparam int IW = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            valid_i = 1'b0;
   logic            result_ready_i = 1'b0;
   logic [NB*AW-1:0] a_re = '0;
   logic [NB*AW-1:0] a_im = '0;
   logic            result_valid_o;
   logic [IW-1:0]   peak_bin_o;
   logic [PW-1:0]   peak_power_o;
   logic            busy_o;
   logic            overrun_o;
`ifdef PEAK_NEIGHBOURS_EN
   logic [PW-1:0]   left_o;
   logic [PW-1:0]   right_o;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   dft_peak_search #(
      .NUM_BINS    (NB),
      .ACCUM_WIDTH (AW),
      .SQ_IN_WIDTH (SQ)
   ) dut (
      .clk_i              (clk_i),
      .rst_ni             (rst_ni),
      .valid_i            (valid_i),
      .A_real_i           (a_re),
      .A_imag_i           (a_im),
      .result_valid_o     (result_valid_o),
      .result_ready_i     (result_ready_i),
      .peak_bin_o         (peak_bin_o),
      .peak_power_o       (peak_power_o),
      .busy_o             (busy_o),
      .overrun_o          (overrun_o)
`ifdef PEAK_NEIGHBOURS_EN
      ,
      .peak_left_power_o  (left_o),
      .peak_right_power_o (right_o)
`endif
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_raw(input int k, input longint re, input longint im);
      a_re[k*AW +: AW] = AW'(re);
      a_im[k*AW +: AW] = AW'(im);
   endtask

   task automatic set_bin(input int k, input longint re, input longint im);
      set_raw(k, re <<< SQ, im <<< SQ);
   endtask

   task automatic pulse_valid();
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int n;
      n = 0;
      while (!result_valid_o && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_reached"}, result_valid_o, 1);
   endtask

   task automatic handshake(input string tag);
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      chk({tag, "_valid_drop"}, result_valid_o, 0);
      chk({tag, "_idle"}, busy_o, 0);
   endtask

   task automatic run(input string tag, input int exp_bin, input longint exp_pow);
      pulse_valid();
      wait_result(tag);
      chk({tag, "_bin"}, peak_bin_o, 64'(exp_bin));
      chk({tag, "_power"}, peak_power_o, 64'(exp_pow));
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_valid", result_valid_o, 0);
      chk("rst_bin", peak_bin_o, 0);
      chk("rst_power", peak_power_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_overrun", overrun_o, 0);
`ifdef PEAK_NEIGHBOURS_EN
      chk("rst_left", left_o, 0);
      chk("rst_right", right_o, 0);
`endif
      rst_ni = 1'b1;
      tick();

      // Single peak with exact latency
      a_re = '0; a_im = '0;
      set_bin(5, 3, 4);
      pulse_valid();
      chk("t1_busy_e0", busy_o, 1);
      repeat (18) tick();
      chk("t1_not_yet_e18", result_valid_o, 0);
      tick();
      chk("t1_valid_e19", result_valid_o, 1);
      chk("t1_bin", peak_bin_o, 5);
      chk("t1_power", peak_power_o, 25);
      handshake("t1");

      // Tie between negative real and positive imag, lowest index wins
      a_re = '0; a_im = '0;
      set_bin(2, -2, 0);
      set_bin(9, 0, 2);
      run("t2", 2, 4);
      handshake("t2");

      // All zero
      a_re = '0; a_im = '0;
      run("t3_zero", 0, 0);
      handshake("t3_zero");

      // Value below the retained MSBs truncates to zero
      a_re = '0; a_im = '0;
      set_raw(15, longint'(1) <<< 23, 0);
      run("t3_trunc", 0, 0);
      handshake("t3_trunc");

      // Most negative parts on the last bin give the largest power
      a_re = '0; a_im = '0;
      set_raw(15, longint'(-1) <<< 47, longint'(-1) <<< 47);
      run("t3_maxneg", 15, longint'(1) <<< 47);
      handshake("t3_maxneg");

      // Backpressure, with a dropped valid_i during the hold
      a_re = '0; a_im = '0;
      set_bin(12, 6, 8);
      pulse_valid();
      wait_result("t4");
      a_re = '0; a_im = '0;
      set_bin(1, 20, 0);
      for (int i = 0; i < 10; i++) begin
         valid_i = (i == 4);
         tick();
         chk("t4_hold_valid", result_valid_o, 1);
         chk("t4_hold_bin", peak_bin_o, 12);
         chk("t4_hold_power", peak_power_o, 100);
         chk("t4_hold_overrun", overrun_o, (i == 4) ? 64'd1 : 64'd0);
      end
      valid_i = 1'b0;
      // Handshake with valid_i in the same cycle: ignored, flagged as overrun
      result_ready_i = 1'b1;
      valid_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      valid_i = 1'b0;
      chk("t4_hs_valid_drop", result_valid_o, 0);
      chk("t4_hs_idle", busy_o, 0);
      chk("t4_hs_overrun", overrun_o, 1);
      tick();
      chk("t4_after_overrun", overrun_o, 0);
      chk("t4_no_restart", busy_o, 0);

      // Reset mid-scan
      a_re = '0; a_im = '0;
      set_bin(3, 3, 4);
      pulse_valid();
      repeat (7) tick();
      @(posedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("t5_rst_valid", result_valid_o, 0);
      chk("t5_rst_busy", busy_o, 0);
      chk("t5_rst_power", peak_power_o, 0);
      chk("t5_rst_bin", peak_bin_o, 0);
      tick();
      rst_ni = 1'b1;
      tick();
      repeat (25) tick();
      chk("t5_stays_idle", result_valid_o, 0);
      a_re = '0; a_im = '0;
      set_bin(10, -1, 2);
      run("t5_new", 10, 5);
      handshake("t5_new");

`ifdef PEAK_NEIGHBOURS_EN
      // Peak at bin 0
      a_re = '0; a_im = '0;
      set_bin(0, 3, 4);
      set_bin(1, 3, 0);
      set_bin(2, 2, 0);
      run("t6a", 0, 25);
      chk("t6a_left", left_o, 0);
      chk("t6a_right", right_o, 9);
      handshake("t6a");

      // Peak in the middle
      a_re = '0; a_im = '0;
      set_bin(0, 1, 0);
      set_bin(6, 2, 0);
      set_bin(7, 5, 0);
      set_bin(8, 3, 0);
      run("t6b", 7, 25);
      chk("t6b_left", left_o, 4);
      chk("t6b_right", right_o, 9);
      handshake("t6b");

      // Peak at the last bin
      a_re = '0; a_im = '0;
      set_bin(14, 4, 0);
      set_bin(15, 10, 0);
      run("t6c", 15, 100);
      chk("t6c_left", left_o, 16);
      chk("t6c_right", right_o, 0);
      handshake("t6c");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
